// File: rtl/bcd_up_timer.sv
// Elapsed mm:ss timer in BCD digits with a 1 s prescaler, start/stop/clear
// control and an optional limit compare that ends the run.
module bcd_up_timer #(
    parameter int TICK_DIV = 31_500_000,
    parameter int PW       = $clog2(TICK_DIV)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        limit_en,
    input  logic [15:0] limit_bcd,
    output logic [3:0]  sec_u,
    output logic [3:0]  sec_t,
    output logic [3:0]  min_u,
    output logic [3:0]  min_t,
    output logic        running,
    output logic        done,
    output logic        tick_1s,
    output logic        rollover
);

    // A divide-by-1 prescaler still needs a one-bit register.
    localparam int CW = (PW < 1) ? 1 : PW;
    localparam logic [CW-1:0] PRESC_MAX = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] presc_q, presc_d;
    logic [15:0]   digits_q, digits_d;   // {min_t, min_u, sec_t, sec_u}
    logic          tick_1s_q, tick_1s_d;
    logic          rollover_q, rollover_d;

    logic          tick_edge;
    logic [16:0]   inc;                  // {wrap, next digits}
    logic          limit_hit;

    // Advance the four-digit chain by one second; MSB flags 59:59 -> 00:00.
    function automatic logic [16:0] bcd_inc(input logic [15:0] d);
        logic [15:0] n;
        logic        c;
        n = d;
        c = 1'b1;
        if (d[3:0] == 4'd9) begin
            n[3:0] = 4'd0;
        end else begin
            n[3:0] = d[3:0] + 4'd1;
            c      = 1'b0;
        end
        if (c) begin
            if (d[7:4] == 4'd5) begin
                n[7:4] = 4'd0;
            end else begin
                n[7:4] = d[7:4] + 4'd1;
                c      = 1'b0;
            end
        end
        if (c) begin
            if (d[11:8] == 4'd9) begin
                n[11:8] = 4'd0;
            end else begin
                n[11:8] = d[11:8] + 4'd1;
                c       = 1'b0;
            end
        end
        if (c) begin
            if (d[15:12] == 4'd5) begin
                n[15:12] = 4'd0;
            end else begin
                n[15:12] = d[15:12] + 4'd1;
                c        = 1'b0;
            end
        end
        return {c, n};
    endfunction

    function automatic logic bcd_valid(input logic [15:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5) &&
               (v[11:8] <= 4'd9) && (v[15:12] <= 4'd5);
    endfunction

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        digits_d   = digits_q;
        tick_1s_d  = 1'b0;
        rollover_d = 1'b0;

        tick_edge = (state_q == S_RUN) && (presc_q == PRESC_MAX);
        inc       = bcd_inc(digits_q);
        limit_hit = limit_en && bcd_valid(limit_bcd) && (inc[15:0] == limit_bcd);

        if (clear) begin
            state_d  = S_IDLE;
            presc_d  = '0;
            digits_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !stop) state_d = S_RUN;
                end
                S_RUN: begin
                    if (tick_edge) begin
                        presc_d    = '0;
                        digits_d   = inc[15:0];
                        tick_1s_d  = 1'b1;
                        rollover_d = inc[16];
                        // A limit match ends the run even if stop arrives on the same edge.
                        if (limit_hit)  state_d = S_DONE;
                        else if (stop)  state_d = S_PAUSE;
                    end else begin
                        presc_d = presc_q + CW'(1);
                        if (stop) state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start && !stop) state_d = S_RUN;
                end
                S_DONE: begin
                    presc_d = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            digits_q   <= '0;
            tick_1s_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            digits_q   <= digits_d;
            tick_1s_q  <= tick_1s_d;
            rollover_q <= rollover_d;
        end
    end

    assign sec_u    = digits_q[3:0];
    assign sec_t    = digits_q[7:4];
    assign min_u    = digits_q[11:8];
    assign min_t    = digits_q[15:12];
    assign running  = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign tick_1s  = tick_1s_q;
    assign rollover = rollover_q;

endmodule

// File: tb/tb_bcd_up_timer.sv
// Bench for bcd_up_timer: directed vector table, multi-cycle corner sequences
// and random control traffic checked against an elapsed-seconds model.
module tb_bcd_up_timer;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stop = 1'b0, clear = 1'b0, limit_en = 1'b0;
    logic [15:0] limit_bcd = 16'h0000;
    logic [3:0]  sec_u, sec_t, min_u, min_t;
    logic        running, done, tick_1s, rollover;

    bcd_up_timer #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .limit_en(limit_en), .limit_bcd(limit_bcd),
        .sec_u(sec_u), .sec_t(sec_t), .min_u(min_u), .min_t(min_t),
        .running(running), .done(done), .tick_1s(tick_1s), .rollover(rollover)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int roll_seen = 0;

    // Model: mode 0 idle, 1 run, 2 pause, 3 done; time kept as plain seconds.
    int m_mode = 0, m_secs = 0, m_pre = 0;
    bit m_tick = 0, m_roll = 0;

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic int dec_limit(input logic [15:0] b);
        if (b[3:0] > 9 || b[7:4] > 5 || b[11:8] > 9 || b[15:12] > 5) return -1;
        return int'(b[15:12]) * 600 + int'(b[11:8]) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [19:0] dut_vec();
        return {min_t, min_u, sec_t, sec_u, running, done, tick_1s, rollover};
    endfunction

    function automatic logic [19:0] model_vec();
        return {to_bcd(m_secs), m_mode == 1, m_mode == 3, m_tick, m_roll};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (digits,run,done,tick,roll)", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_secs = 0; m_pre = 0; m_tick = 0; m_roll = 0;
    endtask

    task automatic model_update();
        int lim;
        lim = dec_limit(limit_bcd);
        m_tick = 0;
        m_roll = 0;
        if (clear) begin
            m_mode = 0; m_secs = 0; m_pre = 0;
        end else if (m_mode == 1) begin
            if (m_pre == TD - 1) begin
                m_pre  = 0;
                m_secs = (m_secs + 1) % 3600;
                m_tick = 1;
                m_roll = (m_secs == 0);
                if (limit_en && lim == m_secs) m_mode = 3;
                else if (stop)                 m_mode = 2;
            end else begin
                m_pre++;
                if (stop) m_mode = 2;
            end
        end else if (m_mode == 0 || m_mode == 2) begin
            if (start && !stop) m_mode = 1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        check("model", dut_vec(), model_vec());
        if (rollover) roll_seen++;
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    typedef struct {
        bit          st, sp, cl, le;
        logic [15:0] lbcd;
        int          ncyc;
        logic [15:0] dig;
        bit          run, dn, tk;
    } vec_t;

    function automatic vec_t mk(bit st, bit sp, bit cl, bit le, logic [15:0] lbcd, int ncyc,
                                logic [15:0] dig, bit run, bit dn, bit tk);
        vec_t v;
        v.st = st; v.sp = sp; v.cl = cl; v.le = le; v.lbcd = lbcd; v.ncyc = ncyc;
        v.dig = dig; v.run = run; v.dn = dn; v.tk = tk;
        return v;
    endfunction

    vec_t tbl[29];

    initial begin
        int r0;
        //             st sp cl le lbcd     n   dig      run dn tk
        tbl[0]  = mk(0, 0, 0, 0, 16'h0000,  1, 16'h0000, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 16'h0000,  1, 16'h0000, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 16'h0000, 40, 16'h0010, 1, 0, 1);
        tbl[3]  = mk(0, 1, 0, 0, 16'h0000,  1, 16'h0010, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 16'h0000, 20, 16'h0010, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 16'h0000,  1, 16'h0010, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 16'h0000,  2, 16'h0010, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 16'h0000,  1, 16'h0011, 1, 0, 1);
        tbl[8]  = mk(0, 0, 1, 0, 16'h0000,  1, 16'h0000, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 1, 16'h0005,  1, 16'h0000, 1, 0, 0);
        tbl[10] = mk(0, 0, 0, 1, 16'h0005, 19, 16'h0004, 1, 0, 0);
        tbl[11] = mk(0, 0, 0, 1, 16'h0005,  1, 16'h0005, 0, 1, 1);
        tbl[12] = mk(1, 0, 0, 1, 16'h0005,  1, 16'h0005, 0, 1, 0);
        tbl[13] = mk(0, 1, 0, 1, 16'h0005,  8, 16'h0005, 0, 1, 0);
        tbl[14] = mk(0, 0, 1, 1, 16'h0005,  1, 16'h0000, 0, 0, 0);
        tbl[15] = mk(1, 0, 0, 1, 16'h00A0,  1, 16'h0000, 1, 0, 0);
        tbl[16] = mk(0, 0, 0, 1, 16'h00A0, 44, 16'h0011, 1, 0, 1);
        tbl[17] = mk(0, 0, 1, 0, 16'h0000,  1, 16'h0000, 0, 0, 0);
        tbl[18] = mk(1, 0, 0, 0, 16'h0000,  1, 16'h0000, 1, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 16'h0000,  3, 16'h0000, 1, 0, 0);
        tbl[20] = mk(0, 1, 0, 0, 16'h0000,  1, 16'h0001, 0, 0, 1);
        tbl[21] = mk(0, 0, 0, 0, 16'h0000,  2, 16'h0001, 0, 0, 0);
        tbl[22] = mk(1, 0, 0, 0, 16'h0000,  1, 16'h0001, 1, 0, 0);
        tbl[23] = mk(0, 0, 0, 0, 16'h0000, 24, 16'h0007, 1, 0, 1);
        tbl[24] = mk(0, 1, 0, 0, 16'h0000,  1, 16'h0007, 0, 0, 0);
        tbl[25] = mk(1, 0, 1, 0, 16'h0000,  1, 16'h0000, 0, 0, 0);
        tbl[26] = mk(0, 0, 0, 0, 16'h0000,  8, 16'h0000, 0, 0, 0);
        tbl[27] = mk(1, 0, 0, 0, 16'h0000,  4, 16'h0000, 1, 0, 0);
        tbl[28] = mk(0, 0, 1, 0, 16'h0000,  1, 16'h0000, 0, 0, 0);

        // Power-on reset: everything zero while reset is held.
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_vec(), 20'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 29; i++) begin
            start = tbl[i].st; stop = tbl[i].sp; clear = tbl[i].cl;
            limit_en = tbl[i].le; limit_bcd = tbl[i].lbcd;
            for (int k = 0; k < tbl[i].ncyc; k++) cyc();
            check($sformatf("vec%0d", i), dut_vec(),
                  {tbl[i].dig, tbl[i].run, tbl[i].dn, tbl[i].tk, 1'b0});
        end

        // Full hour: 59:59 then wrap with a single rollover pulse.
        limit_en = 1'b0;
        start = 1'b1;
        cyc();
        r0 = roll_seen;
        repeat (TD * 3599) cyc();
        check("at_5959", dut_vec(), {16'h5959, 1'b1, 1'b0, 1'b1, 1'b0});
        repeat (TD) cyc();
        check("wrap_0000", dut_vec(), {16'h0000, 1'b1, 1'b0, 1'b1, 1'b1});
        check("roll_count", 20'(roll_seen - r0), 20'd1);
        cyc();
        check("roll_pulse_end", {19'h0, rollover}, 20'h0);

        // Limit 00:00 matches only at rollover, entering DONE on that same edge.
        clear = 1'b1;
        cyc();
        limit_en = 1'b1; limit_bcd = 16'h0000; start = 1'b1;
        cyc();
        repeat (TD * 3600) cyc();
        check("limit_zero", dut_vec(), {16'h0000, 1'b0, 1'b1, 1'b1, 1'b1});
        clear = 1'b1; limit_en = 1'b0;
        cyc();

        // Asynchronous reset mid-second at 01:23.
        start = 1'b1;
        cyc();
        repeat (TD * 83 + 2) cyc();
        check("at_0123", dut_vec(), {16'h0123, 1'b1, 1'b0, 1'b0, 1'b0});
        #1 reset = 1'b1;
        #1 check("async_reset", dut_vec(), 20'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        start = 1'b1;
        cyc();
        repeat (TD - 1) cyc();
        check("post_reset_pre", dut_vec(), {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
        cyc();
        check("post_reset_tick", dut_vec(), {16'h0001, 1'b1, 1'b0, 1'b1, 1'b0});

        // Random control traffic against the model.
        clear = 1'b1;
        cyc();
        for (int n = 0; n < 3000; n++) begin
            int r;
            if ($urandom_range(0, 49) == 0) begin
                limit_en = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) limit_bcd = 16'($urandom);
                else limit_bcd = to_bcd((m_secs + int'($urandom_range(1, 15))) % 3600);
            end
            r = int'($urandom_range(0, 99));
            start = (r < 12);
            stop  = (r >= 12 && r < 18) && !limit_en;
            clear = (r == 99);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
